// File: rtl/downcounter_pkg.sv
// Shared types and constants for the down-counter/timer.
package downcounter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } dct_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/downcounter_prescale.sv
// ce divider: emits one step per pPrescale ce pulses; clr realigns the phase.
module downcounter_prescale #(
  parameter int pPrescale = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ce,
  output logic step
);

  localparam int CW = (pPrescale > 1) ? $clog2(pPrescale) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(pPrescale - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign step = ce && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_TOP;
    end else if (ce) begin
      cnt_d = (cnt_q == '0) ? CNT_TOP : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_TOP;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/downcounter_timer.sv
// Programmable down-counter/timer with reload, one-shot/periodic modes and registered tc.
// Define DOWNCOUNTER_TIMER_PRESCALE_EN to divide ce by pPrescale before counting.
module downcounter_timer
  import downcounter_pkg::*;
#(
  parameter int WID       = 8,
  parameter int pPrescale = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           ld,
  input  logic [WID-1:0] d,
  input  logic           start,
  input  logic           stop,
  input  logic           mode,
  output logic [WID-1:0] q,
  output logic           tc,
  output logic           busy,
  output logic           zero
);

  dct_state_t     state_q, state_d;
  logic [WID-1:0] q_q, q_d;
  logic [WID-1:0] reload_q, reload_d;
  logic           tc_q, tc_d;
  logic           step;

`ifdef DOWNCOUNTER_TIMER_PRESCALE_EN
  logic pre_clr;
  assign pre_clr = ld | start | stop;

  downcounter_prescale #(
    .pPrescale(pPrescale)
  ) u_prescale (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .ce   (ce),
    .step (step)
  );
`else
  assign step = ce;

  // Prescale depth only matters in the prescaled build; keep the range guard visible here too.
  if (pPrescale < 1 || pPrescale > 65536) begin : g_prescale_out_of_range
  end
`endif

  // Commands are mutually exclusive by priority: ld > stop > start > count step.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (ld) begin
      reload_d = d;
      q_d      = d;
    end else if (stop) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
      end
    end else if (start) begin
      state_d = RUN;
      q_d     = reload_q;
    end else if (state_q == RUN && step) begin
      if (q_q != '0) begin
        q_d = q_q - WID'(1);
      end else begin
        tc_d = 1'b1;
        case (mode)
          MODE_PERIODIC: q_d     = reload_q;
          MODE_ONESHOT:  state_d = HALT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign zero = (q_q == '0);

endmodule

// File: tb/tb_downcounter_timer.sv
// Directed self-checking bench for downcounter_timer (default and prescaled builds).
module tb_downcounter_timer;
  import downcounter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, ce, ld, start, stop, mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       tc, busy, zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  downcounter_timer #(
    .WID       (8),
    .pPrescale (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .ld    (ld),
    .d     (d),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .q     (q),
    .tc    (tc),
    .busy  (busy),
    .zero  (zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; ld = 1'b0; start = 1'b0; stop = 1'b0; mode = MODE_ONESHOT; d = 8'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_and_start(input logic [7:0] val, input logic m);
    mode = m; d = val; ld = 1'b1;
    tick();
    ld = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    ld = 1'b1; d = 8'h5A;
    tick();
    ld = 1'b0;
    do_reset();
    checks++;
    if (q !== 8'd0 || tc !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reset: q=%0d tc=%0b busy=%0b zero=%0b required q=0 tc=0 busy=0 zero=1", q, tc, busy, zero);
    end
    $display("reset: q=%0d tc=%0b busy=%0b zero=%0b", q, tc, busy, zero);
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_q [3];
    int tc_seen = 0;
    exp_q = '{8'd2, 8'd1, 8'd0};
    do_reset();
    load_and_start(8'd3, MODE_ONESHOT);
    checks++;
    if (q !== 8'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_start: q=%0d busy=%0b required q=3 busy=1", q, busy);
    end
    ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || tc !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_step%0d: q=%0d tc=%0b busy=%0b required q=%0d tc=0 busy=1", i, q, tc, busy, exp_q[i]);
      end
    end
    tick();
    checks++;
    if (tc !== 1'b1 || q !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_terminal: tc=%0b q=%0d busy=%0b required tc=1 q=0 busy=0", tc, q, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tc === 1'b1) tc_seen++;
      checks++;
      if (q !== 8'd0 || busy !== 1'b0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL oneshot_halt%0d: q=%0d busy=%0b zero=%0b required q=0 busy=0 zero=1", i, q, busy, zero);
      end
    end
    checks++;
    if (tc_seen !== 0) begin
      errors++;
      $display("FAIL oneshot_tc_after_halt: got %0d pulses required 0", tc_seen);
    end
    ce = 1'b0;
    $display("oneshot: done, extra tc pulses in HALT=%0d", tc_seen);
  endtask

  task automatic test_periodic();
    int pulses = 0;
    logic [7:0] eq;
    logic et;
    do_reset();
    load_and_start(8'd2, MODE_PERIODIC);
    ce = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      eq = (k % 3 == 0) ? 8'd2 : 8'(2 - (k % 3));
      et = (k % 3 == 0);
      if (tc === 1'b1) pulses++;
      checks++;
      if (q !== eq || tc !== et || busy !== 1'b1) begin
        errors++;
        $display("FAIL periodic_step%0d: q=%0d tc=%0b busy=%0b required q=%0d tc=%0b busy=1", k, q, tc, busy, eq, et);
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL periodic_pulses: got %0d required 4", pulses);
    end
    ce = 1'b0;
    $display("periodic: %0d tc pulses in 12 steps", pulses);
  endtask

  task automatic test_ce_gating();
    int s = 0;
    int first_tc = -1;
    int second_tc = -1;
    logic [7:0] eq;
    logic et;
    do_reset();
    load_and_start(8'd5, MODE_PERIODIC);
    for (int i = 0; i < 24; i++) begin
      ce = (i % 2 == 0);
      tick();
      if (ce) s++;
      eq = 8'(5 - (s % 6));
      et = ce && (s % 6 == 0);
      if (tc === 1'b1) begin
        if (first_tc < 0) first_tc = i;
        else if (second_tc < 0) second_tc = i;
      end
      checks++;
      if (q !== eq || tc !== et) begin
        errors++;
        $display("FAIL ce_gating_cyc%0d: q=%0d tc=%0b required q=%0d tc=%0b", i, q, tc, eq, et);
      end
    end
    checks++;
    if (second_tc - first_tc !== 12) begin
      errors++;
      $display("FAIL ce_gating_period: got %0d clocks required 12", second_tc - first_tc);
    end
    ce = 1'b0;
    $display("ce_gating: tc at cycles %0d and %0d", first_tc, second_tc);
  endtask

  task automatic test_priority();
    do_reset();
    load_and_start(8'd8, MODE_ONESHOT);
    ce = 1'b1;
    repeat (4) tick();
    checks++;
    if (q !== 8'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL priority_setup: q=%0d busy=%0b required q=4 busy=1", q, busy);
    end
    ld = 1'b1; stop = 1'b1; start = 1'b1; d = 8'd9;
    tick();
    ld = 1'b0; start = 1'b0;
    checks++;
    if (q !== 8'd9 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL priority_ld_wins: q=%0d busy=%0b tc=%0b required q=9 busy=1 tc=0", q, busy, tc);
    end
    tick();
    stop = 1'b0;
    checks++;
    if (q !== 8'd9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL priority_stop: q=%0d busy=%0b required q=9 busy=0", q, busy);
    end
    tick();
    checks++;
    if (q !== 8'd9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL priority_idle_ignores_ce: q=%0d busy=%0b required q=9 busy=0", q, busy);
    end
    ce = 1'b0;
    $display("priority: ld beat stop/start, stop then held q=%0d", q);
  endtask

  task automatic test_reload_zero();
    do_reset();
    load_and_start(8'd0, MODE_PERIODIC);
    ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (tc !== 1'b1 || q !== 8'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload0_periodic%0d: tc=%0b q=%0d busy=%0b required tc=1 q=0 busy=1", i, tc, q, busy);
      end
    end
    ce = 1'b0;
    mode = MODE_ONESHOT; start = 1'b1;
    tick();
    start = 1'b0; ce = 1'b1;
    tick();
    checks++;
    if (tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload0_oneshot: tc=%0b busy=%0b required tc=1 busy=0", tc, busy);
    end
    tick();
    checks++;
    if (tc !== 1'b0) begin
      errors++;
      $display("FAIL reload0_oneshot_single: tc=%0b required 0", tc);
    end
    ce = 1'b0;
    $display("reload_zero: checked periodic and one-shot");
  endtask

  task automatic test_rst_with_start();
    do_reset();
    load_and_start(8'd7, MODE_PERIODIC);
    rst = 1'b1; start = 1'b1; ld = 1'b1; d = 8'd3;
    tick();
    rst = 1'b0; ld = 1'b0;
    checks++;
    if (q !== 8'd0 || busy !== 1'b0 || tc !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL rst_overrides: q=%0d busy=%0b tc=%0b zero=%0b required q=0 busy=0 tc=0 zero=1", q, busy, tc, zero);
    end
    tick();
    start = 1'b0;
    checks++;
    if (q !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_cleared_reload: q=%0d busy=%0b required q=0 busy=1", q, busy);
    end
    $display("rst_with_start: q=%0d after reset", q);
  endtask

  task automatic test_full_range();
    int n = 0;
    do_reset();
    load_and_start(8'hFF, MODE_ONESHOT);
    ce = 1'b1;
    while (tc !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL full_range_steps: got %0d required 256", n);
    end
    ce = 1'b0;
    $display("full_range: tc after %0d steps", n);
  endtask

  task automatic test_prescale();
    int last_tc = 0;
    int n = 0;
    do_reset();
    load_and_start(8'd1, MODE_PERIODIC);
    ce = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      checks++;
      if (tc !== (i % 8 == 0)) begin
        errors++;
        $display("FAIL prescale_cyc%0d: tc=%0b required %0b", i, tc, (i % 8 == 0));
      end
    end
    repeat (2) tick();
    ld = 1'b1; d = 8'd1;
    tick();
    ld = 1'b0;
    while (tc !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    last_tc = n;
    checks++;
    if (last_tc !== 8) begin
      errors++;
      $display("FAIL prescale_ld_realign: got %0d clocks required 8", last_tc);
    end
    ce = 1'b0;
    $display("prescale: tc %0d clocks after mid-phase ld", last_tc);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; ld = 1'b0; start = 1'b0; stop = 1'b0; mode = MODE_ONESHOT; d = 8'd0;
    test_reset();
`ifdef DOWNCOUNTER_TIMER_PRESCALE_EN
    test_prescale();
`else
    test_oneshot();
    test_periodic();
    test_ce_gating();
    test_priority();
    test_reload_zero();
    test_rst_with_start();
    test_full_range();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/downcounter_timer.md
Name: downcounter_timer

Overview:
- Programmable down-counter/timer with reload register, one-shot and periodic modes, and a registered terminal-count pulse.
- Complement to the generic up counter. Used for interval timers, watchdog-style timeouts and rate generators in peripheral blocks.
- Counts down from a loaded value to zero, then either halts or reloads.

Parameters:
- WID, 8: counter and reload register width in bits.
- pPrescale, 4: ce pulses per decrement. Only used when the prescaler is compiled in. Legal range is 1 to 2^16.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  count enable; qualifies decrement steps.
- ld  in  1  load; writes d into the reload register and q. Independent of ce.
- d  in  WID  load value.
- start  in  1  arm or restart the timer; q <= reload.
- stop  in  1  disarm; q holds its value.
- mode  in  1  0 = one-shot, 1 = periodic. Sampled on each terminal event.
- q  out  WID  current count (registered).
- tc  out  1  terminal-count pulse, one cycle wide (registered).
- busy  out  1  high while in RUN.
- zero  out  1  combinational, q == 0.

Behaviour:
- States (enum): IDLE, RUN, HALT.
- Reset: state = IDLE, q = 0, reload = 0, tc = 0, busy = 0, zero = 1.
- Command priority per cycle: rst > ld > stop > start > count step.
- ld, any state:
  - reload <= d and q <= d.
  - State is unchanged, no count step occurs that cycle, tc <= 0.
- stop:
  - RUN or HALT -> IDLE; q holds.
  - No effect in IDLE.
- start:
  - Any state -> RUN; q <= reload; tc <= 0.
  - start while already in RUN is a restart.
- Count step (RUN and ce=1, no higher-priority command):
  - If q != 0: q <= q - 1 (modulo WID, no borrow out), tc <= 0.
  - If q == 0 (terminal event): tc <= 1 the next cycle.
    - mode=1: q <= reload, stay in RUN.
    - mode=0: q holds 0, RUN -> HALT.
- Period is reload + 1 count steps.
  - reload = 0 in periodic mode gives tc on every count step.
  - reload = 0 in one-shot mode gives tc on the first count step after start.
- ce=0 in RUN: q and state hold, tc <= 0.
- tc is never high for two consecutive cycles unless consecutive terminal events occur (reload = 0, ce held high).
- IDLE and HALT: q holds and ce is ignored. In HALT, q stays 0 until ld or start.
- Latency:
  - ld/start to q: 1 cycle.
  - Terminal ce edge to tc high: 1 cycle.
  - busy follows state with no added latency.
- rst mid-count takes effect on that clock edge and overrides ld and start asserted in the same cycle.

Optional Feature:
- Macro: DOWNCOUNTER_TIMER_PRESCALE_EN.
- Defined: an internal prescaler divides ce.
  - A count step occurs only on ce cycles where the prescale count == 0. The prescale count then reloads to pPrescale-1; otherwise it decrements on ce.
  - Prescale count resets to pPrescale-1 on rst, ld, start and stop.
  - Period becomes (reload+1) * pPrescale ce pulses.
- Undefined: every qualified ce cycle is a count step, and pPrescale is ignored.
- Ports are identical in both builds.

Decomposition:
- Package downcounter_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, HALT} dct_state_t.
  - Localparams MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1.
- One sub-module, downcounter_prescale (params pPrescale; ports clk, rst, clr, ce, step).
  - Instantiated only under the macro.
  - Otherwise step = ce.

Test Plan:
- One-shot: rst, ld d=3, start, ce held high, mode=0.
  - q reads 3, 2, 1, 0.
  - tc high exactly once, the cycle after the q == 0 step.
  - State reaches HALT, busy=0, q stays 0 for 10 further cycles.
- Periodic: d=2, mode=1, ce high for 12 cycles after start.
  - tc pulses every 3 count steps (4 pulses total).
  - q sequence repeats 2, 1, 0, 2, ...
- ce gating: d=5, periodic, ce toggling 1010...
  - q decrements only on ce=1 cycles.
  - tc period is 12 clocks.
- Priority: in RUN with q=4, assert ld(d=9), stop and start together.
  - Next cycle q=9, state RUN (ld wins, stop/start ignored).
  - Then stop alone gives IDLE with q holding.
- Edge and reset cases:
  - reload=0, periodic, ce high: tc high every cycle.
  - rst asserted with start at q=7: next cycle q=0, IDLE, tc=0.
  - d=8'hFF one-shot: 256 steps to tc.
- Prescale build (pPrescale=4): d=1, periodic, ce high.
  - tc every 8 cycles.
  - ld mid-prescale restarts the prescale phase.
